// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice: datapath widths, ALU opcode
//   encodings, arbiter FSM state encoding and requester indices.
//   No ports (package).
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_ALUC_W = 5;

    // Requester indices.
    localparam int ARB_REQ_EXU = 0;
    localparam int ARB_REQ_BRU = 1;

    // ALU opcodes. The legal set is contiguous from ADD to ADD_JALR; every
    // other code of the 5-bit space is illegal and must never reach the ALU.
    localparam logic [ARB_ALUC_W-1:0] ALU_ADD      = 5'd0;
    localparam logic [ARB_ALUC_W-1:0] ALU_SUB      = 5'd1;
    localparam logic [ARB_ALUC_W-1:0] ALU_SLL      = 5'd2;
    localparam logic [ARB_ALUC_W-1:0] ALU_SLTU     = 5'd3;
    localparam logic [ARB_ALUC_W-1:0] ALU_XOR      = 5'd4;
    localparam logic [ARB_ALUC_W-1:0] ALU_SRL      = 5'd5;
    localparam logic [ARB_ALUC_W-1:0] ALU_SRA      = 5'd6;
    localparam logic [ARB_ALUC_W-1:0] ALU_OR       = 5'd7;
    localparam logic [ARB_ALUC_W-1:0] ALU_AND      = 5'd8;
    localparam logic [ARB_ALUC_W-1:0] ALU_BEQ      = 5'd9;
    localparam logic [ARB_ALUC_W-1:0] ALU_BNE      = 5'd10;
    localparam logic [ARB_ALUC_W-1:0] ALU_BLT      = 5'd11;
    localparam logic [ARB_ALUC_W-1:0] ALU_BGE      = 5'd12;
    localparam logic [ARB_ALUC_W-1:0] ALU_BLTU     = 5'd13;
    localparam logic [ARB_ALUC_W-1:0] ALU_BGEU     = 5'd14;
    localparam logic [ARB_ALUC_W-1:0] ALU_ADD_LUI  = 5'd15;
    localparam logic [ARB_ALUC_W-1:0] ALU_ADD_JALR = 5'd16;

    // Arbiter FSM state encoding (2 bits).
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu
//   The single combinational ALU shared by the arbiter's requesters.
//   Ports:
//     i_aluc    in  ALUC_W  opcode (always a legal code; the arbiter guards it)
//     i_num1    in  DATA_W  operand 1
//     i_num2    in  DATA_W  operand 2
//     o_result  out DATA_W  result; branch compares return 1/0 in bit 0
// -----------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ALUC_W = ARB_ALUC_W
) (
    input  logic [ALUC_W-1:0] i_aluc,
    input  logic [DATA_W-1:0] i_num1,
    input  logic [DATA_W-1:0] i_num2,
    output logic [DATA_W-1:0] o_result
);

    localparam int SHW = $clog2(DATA_W);

    logic [SHW-1:0]    w_shamt;
    logic [DATA_W-1:0] w_sum;
    logic              w_eq;
    logic              w_lt_s;
    logic              w_lt_u;

    assign w_shamt = i_num2[SHW-1:0];
    assign w_sum   = i_num1 + i_num2;
    assign w_eq    = (i_num1 == i_num2);
    assign w_lt_s  = ($signed(i_num1) < $signed(i_num2));
    assign w_lt_u  = (i_num1 < i_num2);

    always_comb begin
        o_result = '0;
        case (i_aluc)
            ALU_ADD:      o_result = w_sum;
            ALU_SUB:      o_result = i_num1 - i_num2;
            ALU_SLL:      o_result = i_num1 << w_shamt;
            ALU_SLTU:     o_result = {{(DATA_W-1){1'b0}}, w_lt_u};
            ALU_XOR:      o_result = i_num1 ^ i_num2;
            ALU_SRL:      o_result = i_num1 >> w_shamt;
            ALU_SRA:      o_result = $unsigned($signed(i_num1) >>> w_shamt);
            ALU_OR:       o_result = i_num1 | i_num2;
            ALU_AND:      o_result = i_num1 & i_num2;
            ALU_BEQ:      o_result = {{(DATA_W-1){1'b0}}, w_eq};
            ALU_BNE:      o_result = {{(DATA_W-1){1'b0}}, ~w_eq};
            ALU_BLT:      o_result = {{(DATA_W-1){1'b0}}, w_lt_s};
            ALU_BGE:      o_result = {{(DATA_W-1){1'b0}}, ~w_lt_s};
            ALU_BLTU:     o_result = {{(DATA_W-1){1'b0}}, w_lt_u};
            ALU_BGEU:     o_result = {{(DATA_W-1){1'b0}}, ~w_lt_u};
            ALU_ADD_LUI:  o_result = w_sum;
            // Jump target: LSB is always cleared.
            ALU_ADD_JALR: o_result = {w_sum[DATA_W-1:1], 1'b0};
            default:      o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters (0 = EXU integer ops,
//   1 = branch/JALR unit). Round-robin grant, a single op in flight, operands
//   and opcode registered in front of the ALU, result held until accepted.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1 for the same bit. req_ready is combinational from req_valid and the
//   round-robin pointer, only in IDLE, one-hot for the granted requester.
//   rsp_valid is raised only for the owner of the in-flight op; rsp_result and
//   rsp_err hold steady until rsp_ready of that owner is seen.
//
//   Ports:
//     clk         in   1         core clock, all state on rising edge
//     rst         in   1         synchronous, active-high reset
//     req_valid   in   2         bit i: requester i presents an op
//     req_ready   out  2         bit i: op of requester i accepted this cycle
//     req_aluc    in   2*ALUC_W  per-requester opcode, port i at [i*ALUC_W +: ALUC_W]
//     req_num1    in   2*DATA_W  per-requester operand 1
//     req_num2    in   2*DATA_W  per-requester operand 2
//     rsp_valid   out  2         bit i: result for requester i available
//     rsp_ready   in   2         bit i: requester i consumes its result
//     rsp_result  out  DATA_W    result of the in-flight op
//     rsp_err     out  1         op carried an illegal opcode
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ALUC_W = ARB_ALUC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*ALUC_W-1:0] req_aluc,
    input  logic [2*DATA_W-1:0] req_num1,
    input  logic [2*DATA_W-1:0] req_num2,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_err
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;

    logic              r_rr_ptr;
    logic              r_owner;
    logic [ALUC_W-1:0] r_aluc;
    logic [DATA_W-1:0] r_num1;
    logic [DATA_W-1:0] r_num2;
    logic              r_illegal;
    logic [DATA_W-1:0] r_result;
    logic              r_err;

    logic              w_grant;
    logic              w_accept;
    logic              w_rsp_done;
    logic [ALUC_W-1:0] w_sel_aluc;
    logic [DATA_W-1:0] w_sel_num1;
    logic [DATA_W-1:0] w_sel_num2;
    logic              w_sel_legal;
    logic [DATA_W-1:0] w_alu_result;

    // Both requesting: honour the pointer. Otherwise the single requester wins
    // (bit 1 alone -> 1, bit 0 alone -> 0).
    assign w_grant = (req_valid == 2'b11) ? r_rr_ptr : req_valid[1];

    assign w_sel_aluc = w_grant ? req_aluc[2*ALUC_W-1:ALUC_W] : req_aluc[ALUC_W-1:0];
    assign w_sel_num1 = w_grant ? req_num1[2*DATA_W-1:DATA_W] : req_num1[DATA_W-1:0];
    assign w_sel_num2 = w_grant ? req_num2[2*DATA_W-1:DATA_W] : req_num2[DATA_W-1:0];

    // Opcode legality decode; anything outside this list is kept away from the ALU.
    always_comb begin
        w_sel_legal = 1'b0;
        case (w_sel_aluc)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
            ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
            ALU_BGEU, ALU_ADD_LUI, ALU_ADD_JALR: w_sel_legal = 1'b1;
            default:                             w_sel_legal = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|req_valid) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                w_state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Datapath: latched op, round-robin pointer, registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= 1'b0;
            r_owner   <= 1'b0;
            r_aluc    <= ALU_ADD;
            r_num1    <= '0;
            r_num2    <= '0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_owner   <= w_grant;
            r_rr_ptr  <= ~w_grant;
            // An illegal op becomes ADD 0,0 so the ALU only ever sees legal codes.
            r_aluc    <= w_sel_legal ? w_sel_aluc : ALU_ADD;
            r_num1    <= w_sel_legal ? w_sel_num1 : '0;
            r_num2    <= w_sel_legal ? w_sel_num2 : '0;
            r_illegal <= ~w_sel_legal;
        end else if (r_state == ARB_EXEC) begin
            r_result  <= r_illegal ? '0 : w_alu_result;
            r_err     <= r_illegal;
        end else if (w_rsp_done) begin
            // Park the ALU input at ADD 0,0 while idle.
            r_aluc    <= ALU_ADD;
            r_num1    <= '0;
            r_num2    <= '0;
            r_illegal <= 1'b0;
        end
    end

    // Response data is driven only while a response is being offered.
    assign rsp_result = (r_state == ARB_RESP) ? r_result : '0;
    assign rsp_err    = (r_state == ARB_RESP) ? r_err : 1'b0;

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .ALUC_W (ALUC_W)
    ) u_alu (
        .i_aluc   (r_aluc),
        .i_num1   (r_num1),
        .i_num2   (r_num2),
        .o_result (w_alu_result)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. Inputs change 1 ns after the rising
//   edge; a monitor samples on the falling edge, predicts grants, response
//   timing and results, and compares against a queue of expected responses.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*AW-1:0] req_aluc;
    logic [2*DW-1:0] req_num1;
    logic [2*DW-1:0] req_num2;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_result;
    logic            rsp_err;

    alu_arbiter #(.DATA_W(DW), .ALUC_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluc   (req_aluc),
        .req_num1   (req_num1),
        .req_num2   (req_num2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DW:0] exp_q[$];     // {err, result}
    int          grant_log[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    bit          busy    = 1'b0;
    bit          own     = 1'b0;
    bit          rr_exp  = 1'b0;
    int          acc_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit op_legal(input logic [AW-1:0] op);
        return (op <= 5'd16);
    endfunction

    function automatic logic [DW-1:0] model(input logic [AW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        case (op)
            ALU_ADD:      r = a + b;
            ALU_SUB:      r = a - b;
            ALU_SLL:      r = a << b[4:0];
            ALU_SLTU:     r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:      r = a ^ b;
            ALU_SRL:      r = a >> b[4:0];
            ALU_SRA:      r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:       r = a | b;
            ALU_AND:      r = a & b;
            ALU_BEQ:      r = (a == b) ? 32'd1 : 32'd0;
            ALU_BNE:      r = (a != b) ? 32'd1 : 32'd0;
            ALU_BLT:      r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_BGE:      r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            ALU_BLTU:     r = (a < b) ? 32'd1 : 32'd0;
            ALU_BGEU:     r = (a >= b) ? 32'd1 : 32'd0;
            ALU_ADD_LUI:  r = a + b;
            ALU_ADD_JALR: r = (a + b) & 32'hFFFF_FFFE;
            default:      r = '0;
        endcase
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [1:0]    exp_rv;
        logic [1:0]    exp_rr;
        bit            was_busy;
        bit            g;
        logic [AW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy   = 1'b0;
                rr_exp = 1'b0;
                exp_q.delete();
            end else begin
                was_busy = busy;
                exp_rv = (busy && cyc >= acc_cyc + 2) ? (own ? 2'b10 : 2'b01) : 2'b00;
                check("rsp_valid", rsp_valid, exp_rv);
                if (exp_rv != 2'b00 && exp_q.size() > 0) begin
                    check("rsp_result", rsp_result, exp_q[0][DW-1:0]);
                    check("rsp_err", rsp_err, exp_q[0][DW]);
                    if (rsp_ready[own]) begin
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end
                end
                if (was_busy) exp_rr = 2'b00;
                else if (req_valid == 2'b11) exp_rr = rr_exp ? 2'b10 : 2'b01;
                else exp_rr = req_valid;
                check("req_ready", req_ready, exp_rr);
                if (!was_busy && req_ready != 2'b00) grant_log.push_back(int'(req_ready[1]));
                if (exp_rr != 2'b00) begin
                    g  = exp_rr[1];
                    op = g ? req_aluc[2*AW-1:AW] : req_aluc[AW-1:0];
                    a  = g ? req_num1[2*DW-1:DW] : req_num1[DW-1:0];
                    b  = g ? req_num2[2*DW-1:DW] : req_num2[DW-1:0];
                    if (op_legal(op)) exp_q.push_back({1'b0, model(op, a, b)});
                    else exp_q.push_back({1'b1, {DW{1'b0}}});
                    busy    = 1'b1;
                    own     = g;
                    acc_cyc = cyc;
                    rr_exp  = ~g;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int p, input logic [AW-1:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (p == 0) begin
            req_aluc[AW-1:0] = op;
            req_num1[DW-1:0] = a;
            req_num2[DW-1:0] = b;
        end else begin
            req_aluc[2*AW-1:AW] = op;
            req_num1[2*DW-1:DW] = a;
            req_num2[2*DW-1:DW] = b;
        end
    endtask

    // Presents an op and returns 1 ns after the accepting edge (EXEC cycle).
    task automatic issue(input int p, input logic [AW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit ok;
        ok = 1'b0;
        set_op(p, op, a, b);
        req_valid[p] = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[p]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[p] = 1'b0;
        if (!ok) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (!busy && exp_q.size() == 0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_aluc  = '0;
        req_num1  = '0;
        req_num2  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_err", rsp_err, 1'b0);

        // 1: SUB 10-3 on requester 0, response two cycles after accept.
        rsp_ready = 2'b11;
        issue(0, ALU_SUB, 32'd10, 32'd3);
        @(posedge clk);
        #1;
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_result", rsp_result, 32'd7);
        check("t1_err", rsp_err, 1'b0);
        wait_idle();

        // 2: both requesters valid every cycle; grants alternate from reset.
        pulse_reset();
        grant_log.delete();
        set_op(0, ALU_ADD, 32'd1, 32'd1);
        set_op(1, ALU_ADD, 32'd2, 32'd2);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        repeat (14) @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();
        check("t2_grant_count_ge4", 64'(grant_log.size() >= 4), 64'd1);
        if (grant_log.size() >= 4) begin
            check("t2_grant0", grant_log[0], 0);
            check("t2_grant1", grant_log[1], 1);
            check("t2_grant2", grant_log[2], 0);
            check("t2_grant3", grant_log[3], 1);
        end

        // 3: BLT -1 < 1 on requester 1 held with rsp_ready low; no new grant meanwhile.
        rsp_ready = 2'b00;
        issue(1, ALU_BLT, 32'hFFFF_FFFF, 32'd1);
        set_op(0, ALU_ADD, 32'd5, 32'd6);
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;     // non-owner ready must be ignored
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t3_hold_valid", rsp_valid, 2'b10);
            check("t3_hold_result", rsp_result, 32'd1);
            check("t3_no_grant", req_ready, 2'b00);
        end
        rsp_ready = 2'b11;
        issue(0, ALU_ADD, 32'd5, 32'd6);
        wait_idle();

        // 4: illegal opcodes are answered with result 0 and err 1.
        issue(0, 5'd31, 32'h1234, 32'h5678);
        @(posedge clk);
        #1;
        check("t4_rsp_valid", rsp_valid, 2'b01);
        check("t4_result", rsp_result, 32'd0);
        check("t4_err", rsp_err, 1'b1);
        wait_idle();
        issue(1, 5'd17, 32'd9, 32'd9);
        wait_idle();

        // 5: reset during EXEC discards the op; next grant goes to requester 0.
        issue(0, ALU_ADD, 32'd7, 32'd8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_req_ready", req_ready, 2'b00);
        check("t5_rsp_valid", rsp_valid, 2'b00);
        check("t5_rsp_result", rsp_result, 32'd0);
        check("t5_rsp_err", rsp_err, 1'b0);
        set_op(0, ALU_XOR, 32'hF0F0, 32'h0FF0);
        set_op(1, ALU_OR, 32'h1, 32'h2);
        req_valid = 2'b11;
        #1;
        check("t5_grant_req0", req_ready, 2'b01);
        issue(0, ALU_XOR, 32'hF0F0, 32'h0FF0);
        req_valid = 2'b00;
        wait_idle();

        // 6: ADD_JALR clears bit 0; only requester 1 sees the response.
        issue(1, ALU_ADD_JALR, 32'h1001, 32'h4);
        @(posedge clk);
        #1;
        check("t6_rsp_valid", rsp_valid, 2'b10);
        check("t6_result", rsp_result, 32'h1004);
        wait_idle();

        // Random traffic, checked by the monitor.
        for (int i = 0; i < 300; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            set_op(0, 5'($urandom_range(0, 19)), $urandom, $urandom_range(0, 40));
            set_op(1, 5'($urandom_range(0, 19)), $urandom, $urandom_range(0, 40));
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
